// File: rtl/pla_pkg.sv
// Shared literal-encoding constants and width helpers for the programmable AND-OR evaluator.
package pla_pkg;

  // Bit offsets of the two literals of input i inside an AND row (bit 2i + offset).
  localparam int unsigned LIT_TRUE = 0;
  localparam int unsigned LIT_COMP = 1;

  function automatic int unsigned cfg_width(input int unsigned n_in, input int unsigned n_terms);
    return (2 * n_in > n_terms) ? 2 * n_in : n_terms;
  endfunction

  function automatic int unsigned addr_width(input int unsigned n_terms, input int unsigned n_out);
    int unsigned rows;
    rows = n_terms + n_out;
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/pla_pipe_eval_if.sv
// Config port plus input/output valid-ready streams of the pipelined AND-OR evaluator.
interface pla_pipe_eval_if import pla_pkg::*; #(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_TERMS = 2,
  parameter int unsigned N_OUT   = 1
) ();

  localparam int unsigned CFG_W  = cfg_width(N_IN, N_TERMS);
  localparam int unsigned ADDR_W = addr_width(N_TERMS, N_OUT);

  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CFG_W-1:0]  cfg_wdata;
  logic              cfg_ready;
  logic              cfg_err;

  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_data;

  logic              out_valid;
  logic              out_ready;
  logic [N_TERMS-1:0] out_terms;
  logic [N_OUT-1:0]  out_data;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_err, in_ready, out_valid, out_terms, out_data
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
    output cfg_ready, cfg_err, in_ready, out_valid, out_terms, out_data
  );

endinterface

// File: rtl/pla_plane_comb.sv
// Purely combinational AND plane followed by OR plane.
module pla_plane_comb import pla_pkg::*; #(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_TERMS = 2,
  parameter int unsigned N_OUT   = 1
) (
  input  logic [N_IN-1:0]                  x,
  input  logic [N_TERMS-1:0][2*N_IN-1:0]   and_plane,
  input  logic [N_OUT-1:0][N_TERMS-1:0]    or_plane,
  output logic [N_TERMS-1:0]               terms,
  output logic [N_OUT-1:0]                 outs
);

  always_comb begin
    terms = '0;
    outs  = '0;
    for (int unsigned t = 0; t < N_TERMS; t++) begin
      // Start true so an empty row yields 1; any violated literal clears it.
      terms[t] = 1'b1;
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (and_plane[t][2*i+LIT_TRUE] && !x[i]) terms[t] = 1'b0;
        if (and_plane[t][2*i+LIT_COMP] &&  x[i]) terms[t] = 1'b0;
      end
    end
    for (int unsigned o = 0; o < N_OUT; o++) begin
      outs[o] = |(or_plane[o] & terms);
    end
  end

endmodule

// File: rtl/pla_pipe_eval.sv
// Programmable two-level AND-OR evaluator with word-write config and a 2-stage valid/ready pipeline.
module pla_pipe_eval import pla_pkg::*; #(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_TERMS = 2,
  parameter int unsigned N_OUT   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  pla_pipe_eval_if.slave bus
);

  logic [N_TERMS-1:0][2*N_IN-1:0] and_plane;
  logic [N_OUT-1:0][N_TERMS-1:0]  or_plane;

  logic               va;
  logic               vb;
  logic [N_IN-1:0]    a_data;
  logic [N_TERMS-1:0] b_terms;
  logic [N_OUT-1:0]   b_data;
  logic [N_TERMS-1:0] terms_c;
  logic [N_OUT-1:0]   data_c;
  logic               err_q;

  logic in_acc;
  logic b_adv;
  logic cfg_acc;
  logic addr_oor;

  always_comb begin
    b_adv    = va && (!vb || bus.out_ready);
    in_acc   = bus.in_valid && bus.in_ready;
    cfg_acc  = bus.cfg_we && bus.cfg_ready;
    addr_oor = 32'(bus.cfg_addr) >= N_TERMS + N_OUT;
  end

  assign bus.cfg_ready = !va && !vb;
  assign bus.in_ready  = !bus.cfg_we && (!va || !vb || bus.out_ready);
  assign bus.out_valid = vb;
  assign bus.out_terms = b_terms;
  assign bus.out_data  = b_data;
  assign bus.cfg_err   = err_q;

  // Writes only land with the pipeline empty, so stage B never sees a half-updated plane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      and_plane <= '0;
      or_plane  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= cfg_acc && addr_oor;
      if (cfg_acc) begin
        for (int unsigned r = 0; r < N_TERMS; r++) begin
          if (32'(bus.cfg_addr) == r) and_plane[r] <= bus.cfg_wdata[2*N_IN-1:0];
        end
        for (int unsigned r = 0; r < N_OUT; r++) begin
          if (32'(bus.cfg_addr) == N_TERMS + r) or_plane[r] <= bus.cfg_wdata[N_TERMS-1:0];
        end
      end
    end
  end

  pla_plane_comb #(
    .N_IN    (N_IN),
    .N_TERMS (N_TERMS),
    .N_OUT   (N_OUT)
  ) u_planes (
    .x         (a_data),
    .and_plane (and_plane),
    .or_plane  (or_plane),
    .terms     (terms_c),
    .outs      (data_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      va      <= 1'b0;
      vb      <= 1'b0;
      a_data  <= '0;
      b_terms <= '0;
      b_data  <= '0;
    end else begin
      if (in_acc) begin
        a_data <= bus.in_data;
        va     <= 1'b1;
      end else if (b_adv) begin
        va <= 1'b0;
      end

      if (b_adv) begin
        b_terms <= terms_c;
        b_data  <= data_c;
        vb      <= 1'b1;
      end else if (bus.out_ready) begin
        vb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pla_pipe_eval.sv
// Randomised scoreboard bench for pla_pipe_eval against a mask-based reference model.
module tb_pla_pipe_eval;

  localparam int unsigned NI = 4;
  localparam int unsigned NT = 2;
  localparam int unsigned NO = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pla_pipe_eval_if #(.N_IN(NI), .N_TERMS(NT), .N_OUT(NO)) bus ();

  pla_pipe_eval #(.N_IN(NI), .N_TERMS(NT), .N_OUT(NO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [NT-1:0] terms;
    logic [NO-1:0] data;
    bit            lat;
    int            acc;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_mode = 0;
  bit rand_mode = 0;

  logic [2*NI-1:0] and_m [NT];
  logic [NT-1:0]   or_m  [NO];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A term holds when every required-one input is 1 and every required-zero input is 0.
  function automatic logic [NT-1:0] model_terms(input logic [NI-1:0] d);
    logic [NT-1:0] r;
    logic [NI-1:0] ones, zeros;
    r = '0;
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < NI; i++) begin
        ones[i]  = and_m[t][2*i];
        zeros[i] = and_m[t][2*i+1];
      end
      r[t] = ((d & ones) == ones) && ((d & zeros) == '0);
    end
    return r;
  endfunction

  function automatic logic [NO-1:0] model_out(input logic [NT-1:0] tm);
    logic [NO-1:0] r;
    for (int o = 0; o < NO; o++) r[o] = (or_m[o] & tm) != '0;
    return r;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < NT; t++) and_m[t] = '0;
    for (int o = 0; o < NO; o++) or_m[o] = '0;
  endtask

  // Monitor: pops the scoreboard on each output transfer and checks hold stability.
  initial begin : monitor
    bit first = 1;
    bit hold = 0;
    logic [NT-1:0] ht;
    logic [NO-1:0] hd;
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
        first = 1;
        continue;
      end
      if (hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_terms", bus.out_terms, ht);
        check("hold_data", bus.out_data, hd);
      end
      hold = 0;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 0);
        end else begin
          it = q[0];
          if (first && it.lat) check("latency", cyc - it.acc, 2);
          first = 0;
          if (bus.out_ready) begin
            check("out_terms", bus.out_terms, it.terms);
            check("out_data", bus.out_data, it.data);
            void'(q.pop_front());
            first = 1;
          end else begin
            hold = 1;
            ht = bus.out_terms;
            hd = bus.out_data;
          end
        end
      end
    end
  end

  task automatic send(input logic [NI-1:0] d);
    bit ok;
    item_t it;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        it.terms = model_terms(d);
        it.data  = model_out(it.terms);
        it.lat   = lat_mode;
        it.acc   = cyc;
        q.push_back(it);
        ok = 1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
      if (rand_mode && w >= 3) bus.out_ready = 1'b1;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", bus.in_ready, 1);
  endtask

  task automatic cfg_write(input int a, input logic [7:0] d, input int rel);
    bit ok;
    bit oor;
    ok = 0;
    oor = (a >= NT + NO);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a[1:0];
    bus.cfg_wdata = d;
    for (int w = 0; w < 200; w++) begin
      check("cfg_ready_vs_occupancy", bus.cfg_ready, q.size() == 0);
      @(negedge clk);
      check("in_ready_during_cfg", bus.in_ready, 0);
      if (bus.cfg_ready) ok = 1;
      @(posedge clk);
      if (ok) break;
      #1;
      if (w + 1 >= rel) bus.out_ready = 1'b1;
    end
    if (ok) begin
      if (a < NT) and_m[a] = d[2*NI-1:0];
      else if (a < NT + NO) or_m[a-NT] = d[NT-1:0];
    end
    #1;
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b0;
    if (!ok) begin
      check("cfg_timeout", bus.cfg_ready, 1);
    end else begin
      @(negedge clk);
      check("cfg_err_pulse", bus.cfg_err, oor);
      @(posedge clk); #1;
      @(negedge clk);
      check("cfg_err_clear", bus.cfg_err, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    bus.out_ready = 1'b1;
    for (int w = 0; w < 100; w++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_out_terms", bus.out_terms, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Empty config: every term is 1, every output 0.
    bus.out_ready = 1'b1;
    lat_mode = 1;
    send(4'b1111);
    wait_drain();

    // f = a&b | ~c&d with in_data = {a,b,c,d}.
    cfg_write(0, 8'h50, 0);
    cfg_write(1, 8'h09, 0);
    cfg_write(2, 8'h03, 0);
    send(4'b0001);
    send(4'b1100);
    send(4'b0011);
    wait_drain();

    // Backpressure: two inputs fill the pipe, the third stalls.
    lat_mode = 0;
    bus.out_ready = 1'b0;
    send(4'b1101);
    send(4'b0101);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0111;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(4'b0111);
    wait_drain();

    // Config write while busy, with an input offered alongside.
    bus.out_ready = 1'b0;
    send(4'b1100);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0001;
    cfg_write(0, 8'hA0, 4);
    bus.out_ready = 1'b1;
    send(4'b1100);
    send(4'b0000);
    send(4'b1110);
    wait_drain();

    // Contradictory literals on term 0, then an out-of-range write.
    cfg_write(0, 8'h03, 0);
    for (int d = 0; d < 16; d++) send(d[NI-1:0]);
    cfg_write(3, 8'hFF, 0);
    for (int d = 0; d < 4; d++) send(4'(d * 5 + 1));
    wait_drain();

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    send(4'b1001);
    send(4'b0110);
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_terms", bus.out_terms, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_cfg_ready", bus.cfg_ready, 1);
    check("midrst_cfg_err", bus.cfg_err, 0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_stale_out", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    lat_mode = 1;
    send(4'b1111);
    send(4'b0000);
    wait_drain();

    // Random traffic with random backpressure and occasional config writes.
    lat_mode = 0;
    rand_mode = 1;
    for (int n = 0; n < 400; n++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        cfg_write(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 4)));
      end else if ($urandom_range(0, 2) != 0) begin
        send(4'($urandom));
      end else begin
        @(posedge clk); #1;
      end
    end
    rand_mode = 0;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pla_pipe_eval.md
Name: pla_pipe_eval

Overview:
- Parametrised, programmable two-level (AND-OR) logic evaluator; run-time successor to the fixed two-level t1/t2/f gate network.
- AND plane produces N_TERMS product terms from N_IN inputs; OR plane combines terms into N_OUT outputs.
- Both planes are loaded through a word-write config port; evaluation runs through a 2-stage valid/ready pipeline.
- Sits between a stimulus/sequencer source and any downstream consumer needing registered, reconfigurable glue logic.

Parameters:
- N_IN, 4, number of logic inputs
- N_TERMS, 2, number of product terms (AND-plane rows)
- N_OUT, 1, number of outputs (OR-plane rows)
- CFG_W, derived max(2*N_IN, N_TERMS), config data width (localparam, not overridable)
- ADDR_W, derived clog2(N_TERMS+N_OUT), config address width (localparam)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  ADDR_W  0..N_TERMS-1 select AND rows; N_TERMS..N_TERMS+N_OUT-1 select OR rows
- cfg_wdata  in  CFG_W  row contents
- cfg_ready  out  1  high when a write is accepted this cycle
- cfg_err  out  1  one-cycle pulse on an accepted write to an out-of-range address
- in_valid  in  1  input vector valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_data  in  N_IN  input literals; bit i = input i
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_terms  out  N_TERMS  registered product terms belonging to the current out_data
- out_data  out  N_OUT  registered outputs

Behaviour:
- Reset (rst_n low at clk edge): all AND and OR rows cleared to 0; stage valids vA and vB = 0; out_valid = 0; out_terms = 0; out_data = 0; cfg_err = 0. Reset mid-operation discards in-flight data, with no partial output.
- AND row encoding: bit 2i = true literal of input i; bit 2i+1 = complement literal. Term = AND of selected literals. A row with no literals set = 1. A row with both literals of the same input = 0. Bits at or above 2*N_IN are ignored.
- OR row encoding: bit k selects term k. Output = OR of selected terms. An empty row = 0. Bits at or above N_TERMS are ignored.
- Stage A: on accept, registers in_data and sets vA.
- Stage B: on advance, computes terms from the stage-A data and current config, registers outputs, and sets vB. out_terms and out_data come directly from stage-B registers.
- Latency: exactly 2 cycles from accept to out_valid when no backpressure. Throughput: 1 per cycle.
- Flow control:
  - Stage B advances iff vA && (!vB || out_ready).
  - in_ready = !cfg_we && (!vA || !vB || out_ready).
  - Outputs are held stable while out_valid && !out_ready.
- Config writes:
  - cfg_ready = !vA && !vB, i.e. the pipeline is empty.
  - A write is accepted iff cfg_we && cfg_ready. The row updates at that edge and is used by the next accepted input.
  - While cfg_we = 1, no inputs are accepted.
  - Writes with cfg_we && !cfg_ready are dropped; the source must hold cfg_we.
- Out-of-range address (>= N_TERMS+N_OUT) on an accepted write: config unchanged; cfg_err = 1 for the next cycle only.
- Simultaneous events:
  - out_ready with a new accept: pipeline shifts with no bubble.
  - cfg_we with in_valid: config wins and the input stalls.

Decomposition:
- Shared package pla_pkg: literal-encoding constants (LIT_TRUE = 0, LIT_COMP = 1 bit offsets) and a function computing CFG_W / ADDR_W from parameters.
- One sub-module pla_plane_comb: purely combinational AND+OR evaluation, instantiated once in stage B.

Test Plan (default parameters; in_data = {a,b,c,d}):
- Reset then idle -> out_valid = 0, cfg_ready = 1, all-zero config; input 4'b1111 gives out_terms = 2'b11, out_data = 0.
- Program f = a&b | ~c&d: write addr0 = 8'h50, addr1 = 8'h09, addr2 = 2'b11. Then stream 4'b0001, 4'b1100, 4'b0011 back-to-back with out_ready = 1:
  - 4'b0001 -> terms 2'b10, f = 1
  - 4'b1100 -> terms 2'b01, f = 1
  - 4'b0011 -> terms 2'b00, f = 0
  - each result appears 2 cycles after its accept, with no bubbles.
- Backpressure: hold out_ready = 0 for 5 cycles with 3 inputs offered -> 2 accepted, in_ready = 0 thereafter, out_data stable. Release -> remaining result follows in order.
- Config while busy: assert cfg_we with vA = 1 -> cfg_ready = 0, no row change until the pipeline drains. Write lands only then, and in_ready stays 0 throughout.
- Contradictory literal: addr0 = 8'h03 (d and ~d) -> term0 = 0 for all 16 inputs. Write to addr 3 -> cfg_err pulses 1 cycle, config unchanged.
- Reset asserted with both stages valid -> next cycle out_valid = 0, all rows 0, and no stale output after rst_n rises.
